// File: rtl/key_digit_entry.sv
// key_digit_entry: two raw active-low pushbuttons (up/down) become a clean
// WIDTH-bit wrap-around hex digit for the 7-segment decoder.
// Each button gets a 2-flop synchronizer and a debounce FSM that makes one
// press event per accepted press.
// Optional build macro KEY_DIGIT_AUTOREPEAT_EN adds auto-repeat while a
// button is held. The default build has no repeat logic.

module key_digit_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_held,
  output logic o_press_evt
);

  // The counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("key_digit_debounce: DEBOUNCE_CYCLES must be >= 2 and repeat settings >= 1");
  end

  logic [1:0]    r_sync;
  logic          w_pressed;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_held;
  logic          w_debounce_evt;

  // Two-flop synchronizer. Both stages reset to 1, which means released.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_key_n};
    end
  end

  assign w_pressed = ~r_sync[1];

  // Debounce FSM. A press must be stable for DEBOUNCE_CYCLES cycles before
  // it is accepted. A release must also be stable that long.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_held  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_held <= 1'b0;
          r_cnt  <= '0;
          if (w_pressed) begin
            r_state <= ST_PRESS_WAIT;
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_pressed) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_HELD;
            r_held  <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          r_held <= 1'b1;
          r_cnt  <= '0;
          if (!w_pressed) begin
            r_state <= ST_RELEASE_WAIT;
          end
        end
        ST_RELEASE_WAIT: begin
          if (w_pressed) begin
            // A release bounce returns to HELD without a new event.
            r_state <= ST_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_IDLE;
            r_held  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_held  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // The press event pulses for the single cycle in which the FSM commits
  // to HELD. The digit register consumes it on the next edge.
  assign w_debounce_evt = (r_state == ST_PRESS_WAIT) && w_pressed && (r_cnt == CNT_LAST);
  assign o_held         = r_held;

`ifdef KEY_DIGIT_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RCW-1:0] REP_FIRST = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] REP_NEXT  = RCW'(REPEAT_PERIOD - 1);

  logic [RCW-1:0] r_rep_cnt;
  logic           r_rep_armed;
  logic           w_rep_evt;

  assign w_rep_evt = (r_state == ST_HELD) && w_pressed &&
                     (r_rep_armed ? (r_rep_cnt == REP_NEXT) : (r_rep_cnt == REP_FIRST));

  // Repeat timer. It runs only while the FSM is held and the key stays
  // pressed. It restarts on any exit from HELD, including a bounce.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
    end else if ((r_state == ST_HELD) && w_pressed) begin
      if (w_rep_evt) begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b1;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end else begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
    end
  end

  assign o_press_evt = w_debounce_evt | w_rep_evt;
`else
  assign o_press_evt = w_debounce_evt;
`endif

endmodule

module key_digit_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int WIDTH           = 4,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_up_n,
  input  logic             key_down_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] digit,
  output logic             digit_valid,
  output logic             up_held,
  output logic             down_held
);

  logic             w_up_evt;
  logic             w_down_evt;
  logic             w_up_held;
  logic             w_down_held;
  logic [WIDTH-1:0] r_digit;
  logic             r_digit_valid;

  key_digit_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_up (
    .i_clk       (clock),
    .i_rst_n     (reset),
    .i_key_n     (key_up_n),
    .o_held      (w_up_held),
    .o_press_evt (w_up_evt)
  );

  key_digit_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_down (
    .i_clk       (clock),
    .i_rst_n     (reset),
    .i_key_n     (key_down_n),
    .o_held      (w_down_held),
    .o_press_evt (w_down_evt)
  );

  // Digit register. Load wins over presses. Opposing presses cancel.
  // A single press steps the digit with modulo-2**WIDTH wrap.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_digit       <= {WIDTH{1'b0}};
      r_digit_valid <= 1'b0;
    end else if (load) begin
      r_digit       <= load_value;
      r_digit_valid <= 1'b1;
    end else if (w_up_evt && w_down_evt) begin
      r_digit_valid <= 1'b0;
    end else if (w_up_evt) begin
      r_digit       <= r_digit + WIDTH'(1);
      r_digit_valid <= 1'b1;
    end else if (w_down_evt) begin
      r_digit       <= r_digit - WIDTH'(1);
      r_digit_valid <= 1'b1;
    end else begin
      r_digit_valid <= 1'b0;
    end
  end

  assign digit       = r_digit;
  assign digit_valid = r_digit_valid;
  assign up_held     = w_up_held;
  assign down_held   = w_down_held;

endmodule

// File: tb/tb_key_digit_entry.sv
// Self-checking bench for key_digit_entry, with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=20 and REPEAT_PERIOD=8.
// With these settings, a clean press seen at edge 1 moves the digit on edge 7.
module tb_key_digit_entry;

  logic       clock;
  logic       reset;
  logic       key_up_n;
  logic       key_down_n;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] digit;
  logic       digit_valid;
  logic       up_held;
  logic       down_held;

  int tests;
  int failed;
  int pulses;

  key_digit_entry #(
    .DEBOUNCE_CYCLES (4),
    .WIDTH           (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .key_up_n    (key_up_n),
    .key_down_n  (key_down_n),
    .load        (load),
    .load_value  (load_value),
    .digit       (digit),
    .digit_valid (digit_valid),
    .up_held     (up_held),
    .down_held   (down_held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       up_n;
    logic       dn_n;
    logic       ld;
    logic [3:0] lv;
    int         cyc;
    logic [3:0] e_digit;
    int         e_pulses;
    logic       e_uh;
    logic       e_dh;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic up_n, logic dn_n, logic ld, logic [3:0] lv, int cyc,
                              logic [3:0] ed, int ep, logic euh, logic edh);
    vec_t v;
    v.up_n = up_n; v.dn_n = dn_n; v.ld = ld; v.lv = lv; v.cyc = cyc;
    v.e_digit = ed; v.e_pulses = ep; v.e_uh = euh; v.e_dh = edh;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
    if (digit_valid) pulses++;
  endtask

  int bad;
  int exp_digit_ar;
  int exp_pulses_ar;

  initial begin
    tests = 0; failed = 0; pulses = 0;
    reset = 1'b0; key_up_n = 1'b0; key_down_n = 1'b1; load = 1'b0; load_value = 4'h0;

    // Reset held with the up key already down.
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset%0d_digit", i), digit, 0);
      check($sformatf("reset%0d_valid", i), digit_valid, 0);
      check($sformatf("reset%0d_up_held", i), up_held, 0);
    end
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (digit != 4'h0 || digit_valid) bad++;
    end
    check("post_reset_early_change", bad, 0);
    tick();
    check("post_reset_digit", digit, 1);
    check("post_reset_valid", digit_valid, 1);
    check("post_reset_up_held", up_held, 1);
    tick();
    check("post_reset_valid_drop", digit_valid, 0);

    // Table: apply inputs for cyc cycles, then check the end state and the
    // number of valid pulses seen during those cycles.
    vecs.push_back(mk(1, 1, 0, 4'h0, 10, 4'h1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 4'h0,  1, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 10, 4'h1, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 4'h0, 10, 4'h1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 10, 4'h2, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 4'h0, 10, 4'h2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 10, 4'h3, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 4'h0, 10, 4'h3, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, 10, 4'h2, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 4'h0, 10, 4'h2, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, 10, 4'h1, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 4'h0, 10, 4'h1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, 10, 4'h0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 4'h0, 10, 4'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, 10, 4'hF, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 4'h0, 10, 4'hF, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4'h0, 10, 4'hE, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 4'h0, 10, 4'hE, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 4'hF,  1, 4'hF, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 10, 4'h0, 1, 1, 0));
    vecs.push_back(mk(1, 1, 0, 4'h0, 10, 4'h0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 4'h0,  1, 4'h0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 4'h5,  1, 4'h5, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 10, 4'h5, 0, 1, 1));
    vecs.push_back(mk(1, 1, 0, 4'h0, 10, 4'h5, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 10, 4'h6, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 10, 4'h5, 1, 1, 1));
    vecs.push_back(mk(1, 1, 0, 4'h0, 10, 4'h5, 0, 0, 0));

    foreach (vecs[i]) begin
      key_up_n = vecs[i].up_n; key_down_n = vecs[i].dn_n;
      load = vecs[i].ld; load_value = vecs[i].lv;
      pulses = 0;
      for (int c = 0; c < vecs[i].cyc; c++) tick();
      check($sformatf("row%0d_digit", i), digit, vecs[i].e_digit);
      check($sformatf("row%0d_pulses", i), pulses, vecs[i].e_pulses);
      check($sformatf("row%0d_up_held", i), up_held, vecs[i].e_uh);
      check($sformatf("row%0d_down_held", i), down_held, vecs[i].e_dh);
    end
    load = 1'b0;

    // Load arrives in the same cycle as an up event. Load wins, with one pulse.
    key_up_n = 1'b0;
    repeat (6) tick();
    load = 1'b1; load_value = 4'h7;
    tick();
    check("ldcol_digit", digit, 7);
    check("ldcol_valid", digit_valid, 1);
    load = 1'b0;
    pulses = 0;
    repeat (10) tick();
    check("ldcol_extra_pulses", pulses, 0);
    check("ldcol_digit_hold", digit, 7);
    check("ldcol_up_held", up_held, 1);
    key_up_n = 1'b1;
    repeat (10) tick();

    // Press bounce: 2 cycles low, 1 cycle high, repeated 5 times.
    pulses = 0; bad = 0;
    for (int r = 0; r < 5; r++) begin
      key_up_n = 1'b0;
      repeat (2) begin tick(); if (up_held) bad++; end
      key_up_n = 1'b1;
      tick(); if (up_held) bad++;
    end
    repeat (10) begin tick(); if (up_held) bad++; end
    check("bounce_pulses", pulses, 0);
    check("bounce_held_cycles", bad, 0);
    check("bounce_digit", digit, 7);

    // Release bounce: 1-cycle glitches while held must not step again.
    key_up_n = 1'b0;
    pulses = 0;
    repeat (10) tick();
    check("rbounce_press_digit", digit, 8);
    check("rbounce_press_pulses", pulses, 1);
    pulses = 0; bad = 0;
    for (int r = 0; r < 3; r++) begin
      key_up_n = 1'b1;
      tick(); if (!up_held) bad++;
      key_up_n = 1'b0;
      repeat (3) begin tick(); if (!up_held) bad++; end
    end
    repeat (5) begin tick(); if (!up_held) bad++; end
    check("rbounce_pulses", pulses, 0);
    check("rbounce_held_drop", bad, 0);
    check("rbounce_digit", digit, 8);
    key_up_n = 1'b1;
    repeat (10) tick();
    check("rbounce_released", up_held, 0);

    // Long hold: auto-repeat steps when the option is built in.
    load = 1'b1; load_value = 4'h0;
    tick();
    load = 1'b0;
    pulses = 0;
    key_up_n = 1'b0;
    repeat (60) tick();
    key_up_n = 1'b1;
    repeat (10) tick();
`ifdef KEY_DIGIT_AUTOREPEAT_EN
    exp_digit_ar = 6; exp_pulses_ar = 6;
`else
    exp_digit_ar = 1; exp_pulses_ar = 1;
`endif
    check("hold_digit", digit, exp_digit_ar);
    check("hold_pulses", pulses, exp_pulses_ar);
    check("hold_released", up_held, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
